frequency_result_reader: RTL

AXI4-Lite read initiator that consumes the frequency analyzer manager's results. On each rising edge of the manager's irq (write-complete) it reads the six 32-bit action-time registers over an AXI4-Lite master read channel. It presents the values as one snapshot and derives a per-pixel dominant-frequency flag. It sits between the manager's register bank and downstream decision logic, so results can be obtained without processor polling.

---
 rtl/frequency_analyzer_pkg.sv | 24 ++
 rtl/frequency_result_reader_if.sv | 27 ++
 rtl/axi_lite_read_channel.sv | 83 ++++++++
 rtl/frequency_result_reader.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/frequency_analyzer_pkg.sv
// Shared types for the frequency analyzer result path: FSM encoding, register count,
// AXI response code and the slot-to-pixel mapping.
package frequency_analyzer_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StAddr = 2'd1,
    StData = 2'd2,
    StDone = 2'd3
  } state_e;

  localparam int unsigned RegistersNumber = 6;
  localparam logic [1:0]  RespOkay        = 2'b00;

  // Each pixel owns two consecutive slots: even slot holds f0 time, odd slot holds f1 time.
  function automatic int unsigned f0_slot(input int unsigned pixel);
    return 2 * pixel;
  endfunction

  function automatic int unsigned f1_slot(input int unsigned pixel);
    return 2 * pixel + 1;
  endfunction

endpackage

// File: rtl/frequency_result_reader_if.sv
// AXI4-Lite read address/data channels between the result reader (master) and the
// manager register bank (slave).
interface frequency_result_reader_if #(
  parameter int unsigned AddrWidth = 10,
  parameter int unsigned DataWidth = 32
);

  logic [AddrWidth-1:0] araddr;
  logic [2:0]           arprot;
  logic                 arvalid;
  logic                 arready;
  logic [DataWidth-1:0] rdata;
  logic [1:0]           rresp;
  logic                 rvalid;
  logic                 rready;

  modport master (
    output araddr, arprot, arvalid, rready,
    input  arready, rdata, rresp, rvalid
  );

  modport slave (
    input  araddr, arprot, arvalid, rready,
    output arready, rdata, rresp, rvalid
  );

endinterface

// File: rtl/axi_lite_read_channel.sv
// Single-outstanding AXI4-Lite read: issues one address on start, accepts one beat.
// Optional watchdog (READ_TIMEOUT_EN) aborts a read stuck in the address or data phase.
module axi_lite_read_channel #(
  parameter int unsigned AddrWidth = 10,
  parameter int unsigned DataWidth = 32
`ifdef READ_TIMEOUT_EN
  ,
  parameter int unsigned TimeoutCycles = 1024
`endif
) (
  input  logic                     m00_axi_aclk,
  input  logic                     m00_axi_aresetn,
  input  logic                     start,
  input  logic [AddrWidth-1:0]     addr,
  output logic                     addr_accepted,
  output logic                     done,
  output logic                     timeout,
  output logic [DataWidth-1:0]     data,
  output logic [1:0]               resp,
  frequency_result_reader_if.master axi
);

  logic                 arvalid_q;
  logic                 rready_q;
  logic [AddrWidth-1:0] araddr_q;

  assign addr_accepted = arvalid_q & axi.arready;
  assign done          = rready_q & axi.rvalid;
  assign data          = axi.rdata;
  assign resp          = axi.rresp;

  assign axi.araddr  = araddr_q;
  assign axi.arprot  = 3'b000;
  assign axi.arvalid = arvalid_q;
  assign axi.rready  = rready_q;

  always_ff @(posedge m00_axi_aclk or negedge m00_axi_aresetn) begin
    if (!m00_axi_aresetn) begin
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      araddr_q  <= '0;
    end else if (timeout) begin
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
    end else begin
      // A new start can coincide with the final data beat of the previous read.
      if (start) begin
        arvalid_q <= 1'b1;
        araddr_q  <= addr;
      end else if (addr_accepted) begin
        arvalid_q <= 1'b0;
      end
      if (addr_accepted) begin
        rready_q <= 1'b1;
      end else if (done) begin
        rready_q <= 1'b0;
      end
    end
  end

`ifdef READ_TIMEOUT_EN
  localparam int unsigned WdWidth = $clog2(TimeoutCycles);

  logic [WdWidth-1:0] wd_q;

  // A completing handshake wins over an expiring watchdog in the same cycle.
  assign timeout = (arvalid_q | rready_q) & (wd_q == WdWidth'(TimeoutCycles - 1)) &
                   ~addr_accepted & ~done;

  always_ff @(posedge m00_axi_aclk or negedge m00_axi_aresetn) begin
    if (!m00_axi_aresetn) begin
      wd_q <= '0;
    end else if (start || addr_accepted || timeout) begin
      wd_q <= '0;
    end else if (arvalid_q || rready_q) begin
      wd_q <= wd_q + 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: rtl/frequency_result_reader.sv
// Reads the manager's action-time registers on each irq rising edge and publishes them as one
// snapshot with per-pixel dominant-frequency flags. READ_TIMEOUT_EN adds a read watchdog.
module frequency_result_reader
  import frequency_analyzer_pkg::*;
#(
  parameter int unsigned C_M00_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_M00_AXI_ADDR_WIDTH = 10,
  parameter int unsigned BASE_ADDR            = 0,
  parameter int unsigned REGISTERS_NUMBER     = RegistersNumber
`ifdef READ_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYCLES       = 1024
`endif
) (
  input  logic                                             m00_axi_aclk,
  input  logic                                             m00_axi_aresetn,
  input  logic                                             irq,
  frequency_result_reader_if.master                        m00_axi,
  output logic [C_M00_AXI_DATA_WIDTH*REGISTERS_NUMBER-1:0] values,
  output logic [REGISTERS_NUMBER/2-1:0]                    pixel_state,
  output logic                                             result_valid,
  output logic                                             busy,
  output logic                                             error
);

  localparam int unsigned DataW     = C_M00_AXI_DATA_WIDTH;
  localparam int unsigned IdxW      = $clog2(REGISTERS_NUMBER);
  localparam int unsigned NumPixels = REGISTERS_NUMBER / 2;

  state_e                               state_q;
  logic [IdxW-1:0]                      idx_q;
  logic                                 irq_q;
  logic                                 pending_q;
  logic                                 busy_q;
  logic                                 error_q;
  logic                                 result_valid_q;
  logic [NumPixels-1:0]                 pixel_q;
  logic [DataW*REGISTERS_NUMBER-1:0]    values_q;

  logic                                 trigger;
  logic                                 go;
  logic                                 last_word;
  logic                                 word_done;
  logic                                 bad_resp;
  logic                                 rd_start;
  logic [IdxW-1:0]                      next_idx;
  logic [C_M00_AXI_ADDR_WIDTH-1:0]      rd_addr;
  logic                                 rd_addr_accepted;
  logic                                 rd_done;
  logic                                 rd_timeout;
  logic [DataW-1:0]                     rd_data;
  logic [1:0]                           rd_resp;
  logic [DataW*REGISTERS_NUMBER-1:0]    values_nxt;
  logic [NumPixels-1:0]                 pixel_nxt;

  assign trigger   = irq & ~irq_q;
  assign go        = (state_q == StIdle) & (trigger | pending_q);
  assign last_word = (idx_q == IdxW'(REGISTERS_NUMBER - 1));
  assign word_done = (state_q == StData) & rd_done;
  assign bad_resp  = (rd_resp != RespOkay);
  assign rd_start  = go | (word_done & ~last_word);
  assign next_idx  = (state_q == StIdle) ? '0 : idx_q + 1'b1;
  assign rd_addr   = C_M00_AXI_ADDR_WIDTH'(BASE_ADDR + 4 * 32'(next_idx));

  axi_lite_read_channel #(
    .AddrWidth    (C_M00_AXI_ADDR_WIDTH),
    .DataWidth    (DataW)
`ifdef READ_TIMEOUT_EN
    ,
    .TimeoutCycles(TIMEOUT_CYCLES)
`endif
  ) u_read_channel (
    .m00_axi_aclk   (m00_axi_aclk),
    .m00_axi_aresetn(m00_axi_aresetn),
    .start          (rd_start),
    .addr           (rd_addr),
    .addr_accepted  (rd_addr_accepted),
    .done           (rd_done),
    .timeout        (rd_timeout),
    .data           (rd_data),
    .resp           (rd_resp),
    .axi            (m00_axi)
  );

  // Slots fill progressively; the flags are taken from the view including the final beat.
  always_comb begin
    values_nxt = values_q;
    if (word_done) begin
      values_nxt[DataW*32'(idx_q) +: DataW] = rd_data;
    end
  end

  always_comb begin
    pixel_nxt = '0;
    for (int unsigned p = 0; p < NumPixels; p++) begin
      pixel_nxt[p] = values_nxt[DataW*f1_slot(p) +: DataW] > values_nxt[DataW*f0_slot(p) +: DataW];
    end
  end

  always_ff @(posedge m00_axi_aclk or negedge m00_axi_aresetn) begin
    if (!m00_axi_aresetn) begin
      state_q        <= StIdle;
      idx_q          <= '0;
      // Treat irq as already high so a level held across reset does not count as an edge.
      irq_q          <= 1'b1;
      pending_q      <= 1'b0;
      busy_q         <= 1'b0;
      error_q        <= 1'b0;
      result_valid_q <= 1'b0;
      pixel_q        <= '0;
      values_q       <= '0;
    end else begin
      irq_q          <= irq;
      values_q       <= values_nxt;
      result_valid_q <= 1'b0;
      if (trigger && (state_q != StIdle)) begin
        pending_q <= 1'b1;
      end
      unique case (state_q)
        StIdle: begin
          if (go) begin
            state_q   <= StAddr;
            idx_q     <= '0;
            error_q   <= 1'b0;
            pending_q <= 1'b0;
            busy_q    <= 1'b1;
          end
        end
        StAddr: begin
          if (rd_timeout) begin
            error_q <= 1'b1;
            pixel_q <= pixel_nxt;
            state_q <= StDone;
          end else if (rd_addr_accepted) begin
            state_q <= StData;
          end
        end
        StData: begin
          if (rd_timeout) begin
            error_q <= 1'b1;
            pixel_q <= pixel_nxt;
            state_q <= StDone;
          end else if (rd_done) begin
            if (bad_resp) begin
              error_q <= 1'b1;
            end
            if (last_word) begin
              state_q        <= StDone;
              pixel_q        <= pixel_nxt;
              result_valid_q <= ~(error_q | bad_resp);
            end else begin
              idx_q   <= idx_q + 1'b1;
              state_q <= StAddr;
            end
          end
        end
        StDone: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign values       = values_q;
  assign pixel_state  = pixel_q;
  assign result_valid = result_valid_q;
  assign busy         = busy_q;
  assign error        = error_q;

endmodule
